data_mem_responder: RTL

- Memory-side responder for the core's data port: accepts one load/store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then performs the access on an internal byte-lane word array.
- Returns load data formatted per RV32I funct3 (sign/zero extension), or flags an error.
- Sits between the core's MEM stage and data storage; it is the responder end of the core's data-memory interface.

---
 rtl/data_mem_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, RV32I load formatting.
// Define DMEM_PERF_CNT_EN to add the perf_access_cnt / perf_err_cnt response counters.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 13,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_access_cnt,
  output logic [15:0] perf_err_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      funct3_q;
  logic [31:0]     wdata_q;
  logic            err_q;

  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [2:0]      cur_funct3;
  logic [31:0]     cur_wdata;
  logic            cur_err;
  logic            accept;
  logic            access;
  logic [3:0]      byte_en;
  logic [3:0]      mem_we;
  logic            mem_re;
  logic [31:0]     wdata_rep;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [31:0]     load_fmt;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    cur_write  = write_q;
    cur_addr   = addr_q;
    cur_funct3 = funct3_q;
    cur_wdata  = wdata_q;
    if (state_q == S_IDLE) begin
      cur_write  = req_write;
      cur_addr   = req_addr[AW-1:0];
      cur_funct3 = req_funct3;
      cur_wdata  = req_wdata;
    end
  end

  always_comb begin
    cur_err = 1'b0;
    if (cur_funct3[1:0] == 2'b11) begin
      cur_err = 1'b1;
    end else if (cur_funct3[2] && (cur_write || cur_funct3[1])) begin
      cur_err = 1'b1;
    end else if ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) begin
      cur_err = 1'b1;
    end else if ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)) begin
      cur_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr[AW-1:0];
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        err_q    <= cur_err;
      end
    end
  end

  always_comb begin
    case (cur_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << cur_addr[1:0];
        wdata_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = cur_wdata;
      end
    endcase
  end

  // Reset gating keeps a store from landing while the FSM is being forced back to IDLE.
  assign mem_we  = (access && cur_write && !cur_err && !reset) ? byte_en : 4'b0000;
  assign mem_re  = access && !cur_write && !cur_err && !reset;
  assign mem_idx = cur_addr[AW-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem_q [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (mem_we[gi]) begin
          lane_mem_q[mem_idx] <= wdata_rep[8*gi +: 8];
        end
        if (mem_re) begin
          rd_q <= lane_mem_q[mem_idx];
        end
      end
      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_fmt = {24'd0, rd_shift[7:0]};
      3'b001:  load_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_fmt = {16'd0, rd_shift[15:0]};
      default: load_fmt = rd_word;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? load_fmt : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_access_q;
  logic [15:0] perf_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_access_q <= 32'd0;
      perf_err_q    <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      perf_access_q <= perf_access_q + 32'd1;
      if (err_q) begin
        perf_err_q <= perf_err_q + 16'd1;
      end
    end
  end

  assign perf_access_cnt = perf_access_q;
  assign perf_err_cnt    = perf_err_q;
`endif

endmodule
